// File: rtl/eeprom_seq_pkg.sv
// Shared definitions for the EEPROM transaction sequencer.
//   state_t  : sequencer FSM states
//   MODE_*   : MODE input encodings (3 is reserved and behaves like MODE_WV)
//   clog2w() : clog2 clamped to a minimum width of 1
package eeprom_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_PULSE,
        ST_WAIT_ACK,
        ST_CHECK,
        ST_PHASE_SW,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_WV = 2'd0;  // write then verify
    localparam logic [1:0] MODE_WO = 2'd1;  // write only
    localparam logic [1:0] MODE_RO = 2'd2;  // read/verify only

    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ack_edge_timer.sv
// ACK rising-edge detector plus ACK timeout down-counter.
//   CLK, RESET_N : clock, synchronous active-low reset
//   ACK          : controller acknowledge (same clock domain)
//   clr          : reload the timer with ACK_TIMEOUT
//   en           : count down one step per cycle
//   ack_rise     : ACK_q & ~ACK_qq
//   expired      : high in the last enabled cycle of the timeout window
module ack_edge_timer
    import eeprom_seq_pkg::*;
#(
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic ACK,
    input  logic clr,
    input  logic en,
    output logic ack_rise,
    output logic expired
);

    localparam int TMR_W = clog2w(ACK_TIMEOUT + 1);

    logic             ack_q;
    logic             ack_qq;
    logic [TMR_W-1:0] tmr;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ack_q  <= 1'b0;
            ack_qq <= 1'b0;
            tmr    <= '0;
        end else begin
            ack_q  <= ACK;
            ack_qq <= ack_q;
            if (clr)
                tmr <= TMR_W'(ACK_TIMEOUT);
            else if (en && tmr != '0)
                tmr <= tmr - 1'b1;
        end
    end

    assign ack_rise = ack_q & ~ack_qq;
    // Terminal count at 1 so that exactly ACK_TIMEOUT enabled cycles elapse.
    assign expired  = en && (tmr == TMR_W'(1));

endmodule

// File: rtl/eeprom_txn_sequencer.sv
// Table-driven EEPROM write/verify sequencer.
//   START/MODE           : launch a sequence (write+verify, write only, read only)
//   TBL_IDX -> TBL_ADDR/TBL_DATA : combinational table lookup
//   WR/RD/ADDR/DATA_O/DATA_OE    : request side of the EEPROM controller
//   DATA_I/ACK           : controller response
//   BUSY/DONE/TIMEOUT_ERR: status; PASS_CNT/FAIL_CNT/FIRST_FAIL_IDX: verify results
//
// state       | meaning
// ------------+----------------------------------------------
// ST_IDLE     | waiting for START
// ST_LOAD     | latch address/data from the table entry
// ST_GAP      | GAP_CYC idle cycles before the request pulse
// ST_PULSE    | WR or RD high for PULSE_CYC cycles
// ST_WAIT_ACK | wait for ACK rising edge or timeout
// ST_CHECK    | compare read-back data with expected value
// ST_PHASE_SW | PHASE_GAP idle cycles (min 1) between write and read phases
// ST_DONE     | one cycle; DONE pulse unless a timeout ended the run
module eeprom_txn_sequencer
    import eeprom_seq_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int NUM_TXN     = 16,
    parameter int GAP_CYC     = 5,
    parameter int PULSE_CYC   = 1,
    parameter int PHASE_GAP   = 10,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic                               CLK,
    input  logic                               RESET_N,
    input  logic                               START,
    input  logic [1:0]                         MODE,
    output logic [clog2w(NUM_TXN)-1:0]         TBL_IDX,
    input  logic [ADDR_W-1:0]                  TBL_ADDR,
    input  logic [DATA_W-1:0]                  TBL_DATA,
    output logic                               WR,
    output logic                               RD,
    output logic [ADDR_W-1:0]                  ADDR,
    output logic [DATA_W-1:0]                  DATA_O,
    output logic                               DATA_OE,
    input  logic [DATA_W-1:0]                  DATA_I,
    input  logic                               ACK,
    output logic                               BUSY,
    output logic                               DONE,
    output logic                               TIMEOUT_ERR,
    output logic [clog2w(NUM_TXN+1)-1:0]       PASS_CNT,
    output logic [clog2w(NUM_TXN+1)-1:0]       FAIL_CNT,
    output logic [clog2w(NUM_TXN)-1:0]         FIRST_FAIL_IDX
);

    localparam int IDX_W   = clog2w(NUM_TXN);
    localparam int DLY_MAX = (GAP_CYC > PULSE_CYC)
                           ? ((GAP_CYC > PHASE_GAP) ? GAP_CYC : PHASE_GAP)
                           : ((PULSE_CYC > PHASE_GAP) ? PULSE_CYC : PHASE_GAP);
    localparam int DLY_W   = clog2w(DLY_MAX + 1);
    localparam int PSW_LD  = (PHASE_GAP > 0) ? PHASE_GAP - 1 : 0;

    state_t             state, state_nxt;
    logic               phase_rd;
    logic [1:0]         mode_q;
    logic [IDX_W-1:0]   idx;
    logic [DLY_W-1:0]   dly;
    logic [DATA_W-1:0]  expected;
    logic [DATA_W-1:0]  rd_data;
    logic               last_txn;
    logic               adv_go;
    state_t             adv_state;
    logic               tmr_clr, tmr_en, ack_rise, expired;

    ack_edge_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_tmr (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .ACK      (ACK),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .ack_rise (ack_rise),
        .expired  (expired)
    );

    assign last_txn = (idx == IDX_W'(NUM_TXN - 1));

    always_comb begin
        adv_state = ST_DONE;
        if (!last_txn)
            adv_state = ST_LOAD;
        else if (!phase_rd && mode_q != MODE_WO && mode_q != MODE_RO)
            adv_state = ST_PHASE_SW;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tmr_clr   = 1'b1;
        tmr_en    = 1'b0;
        adv_go    = 1'b0;
        case (state)
            ST_IDLE:     if (START) state_nxt = ST_LOAD;
            ST_LOAD:     state_nxt = ST_GAP;
            ST_GAP:      if (dly == '0) state_nxt = ST_PULSE;
            ST_PULSE:    if (dly == '0) state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                if (ack_rise) begin
                    if (phase_rd) begin
                        state_nxt = ST_CHECK;
                    end else begin
                        state_nxt = adv_state;
                        adv_go    = 1'b1;
                    end
                end else if (expired) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_CHECK: begin
                state_nxt = adv_state;
                adv_go    = 1'b1;
            end
            ST_PHASE_SW: if (dly == '0) state_nxt = ST_LOAD;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            phase_rd       <= 1'b0;
            mode_q         <= MODE_WV;
            idx            <= '0;
            dly            <= '0;
            expected       <= '0;
            rd_data        <= '0;
            ADDR           <= '0;
            DATA_O         <= '0;
            DATA_OE        <= 1'b0;
            TIMEOUT_ERR    <= 1'b0;
            PASS_CNT       <= '0;
            FAIL_CNT       <= '0;
            FIRST_FAIL_IDX <= '0;
        end else begin
            case (state)
                ST_IDLE: if (START) begin
                    PASS_CNT       <= '0;
                    FAIL_CNT       <= '0;
                    FIRST_FAIL_IDX <= '0;
                    TIMEOUT_ERR    <= 1'b0;
                    DATA_OE        <= 1'b0;
                    idx            <= '0;
                    mode_q         <= MODE;
                    phase_rd       <= (MODE == MODE_RO);
                end
                ST_LOAD: begin
                    ADDR     <= TBL_ADDR;
                    expected <= TBL_DATA;
                    dly      <= DLY_W'(GAP_CYC - 1);
                    if (!phase_rd) begin
                        DATA_O  <= TBL_DATA;
                        DATA_OE <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (dly == '0)
                        dly <= DLY_W'(PULSE_CYC - 1);
                    else
                        dly <= dly - 1'b1;
                end
                ST_PULSE, ST_PHASE_SW: if (dly != '0) dly <= dly - 1'b1;
                ST_WAIT_ACK: begin
                    if (ack_rise) begin
                        if (phase_rd) rd_data <= DATA_I;
                    end else if (expired) begin
                        TIMEOUT_ERR <= 1'b1;
                        DATA_OE     <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (rd_data == expected) begin
                        PASS_CNT <= PASS_CNT + 1'b1;
                    end else begin
                        FAIL_CNT <= FAIL_CNT + 1'b1;
                        if (FAIL_CNT == '0) FIRST_FAIL_IDX <= idx;
                    end
                end
                default: ;
            endcase

            // Shared end-of-transaction bookkeeping for write ACK and CHECK.
            if (adv_go) begin
                case (adv_state)
                    ST_LOAD:     idx <= idx + 1'b1;
                    ST_PHASE_SW: begin
                        DATA_OE  <= 1'b0;
                        phase_rd <= 1'b1;
                        idx      <= '0;
                        dly      <= DLY_W'(PSW_LD);
                    end
                    default:     DATA_OE <= 1'b0;
                endcase
            end
        end
    end

    assign TBL_IDX = idx;
    assign WR      = (state == ST_PULSE) && !phase_rd;
    assign RD      = (state == ST_PULSE) &&  phase_rd;
    assign BUSY    = (state != ST_IDLE) && (state != ST_DONE);
    assign DONE    = (state == ST_DONE) && !TIMEOUT_ERR;

endmodule

// File: tb/tb_eeprom_txn_sequencer.sv
module tb_eeprom_txn_sequencer;

    localparam int K_WR = 0, K_RD = 1, K_DONE = 2, K_TO = 3;

    typedef struct {
        int          kind;
        logic [10:0] addr;
        logic [7:0]  data;
        int          pcnt;
        int          fcnt;
        int          ffi;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic [1:0]  MODE = 2'd0;
    logic [1:0]  TBL_IDX;
    logic [10:0] TBL_ADDR;
    logic [7:0]  TBL_DATA;
    logic        WR, RD, DATA_OE, BUSY, DONE, TIMEOUT_ERR;
    logic [10:0] ADDR;
    logic [7:0]  DATA_O;
    logic [7:0]  DATA_I;
    logic        ACK;
    logic        ack_model, ack_inject;
    logic [2:0]  PASS_CNT, FAIL_CNT;
    logic [1:0]  FIRST_FAIL_IDX;

    logic [10:0] tbl_addr [4];
    logic [7:0]  tbl_data [4];
    logic [7:0]  mem [2048];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    logic        ack_en = 1'b1;
    logic        corrupt_en = 1'b0;
    logic [10:0] corrupt_addr = 11'h011;

    always #5 CLK = ~CLK;

    assign TBL_ADDR = tbl_addr[TBL_IDX];
    assign TBL_DATA = tbl_data[TBL_IDX];
    assign ACK      = ack_model | ack_inject;

    eeprom_txn_sequencer #(
        .ADDR_W(11), .DATA_W(8), .NUM_TXN(4), .GAP_CYC(5), .PULSE_CYC(2),
        .PHASE_GAP(10), .ACK_TIMEOUT(32)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .MODE(MODE),
        .TBL_IDX(TBL_IDX), .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA),
        .WR(WR), .RD(RD), .ADDR(ADDR), .DATA_O(DATA_O), .DATA_OE(DATA_OE),
        .DATA_I(DATA_I), .ACK(ACK), .BUSY(BUSY), .DONE(DONE),
        .TIMEOUT_ERR(TIMEOUT_ERR), .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT),
        .FIRST_FAIL_IDX(FIRST_FAIL_IDX)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int kind, input logic [10:0] a, input logic [7:0] d,
                                input int p, input int f, input int ffi);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.pcnt = p; e.fcnt = f; e.ffi = ffi;
        return e;
    endfunction

    // Controller model: captures writes, returns reads, ACKs 3 cycles after a pulse ends.
    initial begin
        int   dly;
        logic pulse_prev;
        dly = 0; pulse_prev = 1'b0; ack_model = 1'b0; DATA_I = 8'h00;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                dly = 0; pulse_prev = 1'b0; ack_model = 1'b0;
            end else begin
                if (WR) mem[ADDR] = DATA_O;
                if (RD) DATA_I = (corrupt_en && ADDR == corrupt_addr) ? 8'h00 : mem[ADDR];
                ack_model = 1'b0;
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) ack_model = 1'b1;
                end
                if (pulse_prev && !(WR | RD) && ack_en) dly = 3;
                pulse_prev = WR | RD;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a pulse or status event.
    initial begin
        int   cyc, wr_w, rd_w, pulse_end, oe_fall;
        logic wr_p, rd_p, oe_p, te_p;
        exp_t e;
        cyc = 0; wr_w = 0; rd_w = 0; pulse_end = 0; oe_fall = -1;
        wr_p = 0; rd_p = 0; oe_p = 0; te_p = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RESET_N) begin
                wr_p = 0; rd_p = 0; oe_p = 0; te_p = 0; wr_w = 0; rd_w = 0; oe_fall = -1;
            end else begin
                if (WR && !wr_p) begin
                    wr_w = 1;
                    chk("wr_rd_exclusive", {31'd0, RD}, 32'd0);
                    if (q.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
                    else begin
                        e = q.pop_front();
                        chk("wr_kind", e.kind, K_WR);
                        chk("wr_addr", ADDR, e.addr);
                        chk("wr_data", DATA_O, e.data);
                        chk("wr_oe", DATA_OE, 1);
                    end
                end else if (WR) wr_w++;
                else if (wr_p) begin
                    chk("wr_width", wr_w, 2);
                    pulse_end = cyc;
                end

                if (RD && !rd_p) begin
                    rd_w = 1;
                    chk("wr_rd_exclusive", {31'd0, WR}, 32'd0);
                    if (q.size() == 0) chk("unexpected_rd", 32'd1, 32'd0);
                    else begin
                        e = q.pop_front();
                        chk("rd_kind", e.kind, K_RD);
                        chk("rd_addr", ADDR, e.addr);
                        chk("rd_oe", DATA_OE, 0);
                    end
                    if (oe_fall >= 0) begin
                        chk("phase_gap", cyc - oe_fall, 16);
                        oe_fall = -1;
                    end
                end else if (RD) rd_w++;
                else if (rd_p) begin
                    chk("rd_width", rd_w, 2);
                    pulse_end = cyc;
                end

                if (oe_p && !DATA_OE && BUSY) oe_fall = cyc;

                if (DONE) begin
                    if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                    else begin
                        e = q.pop_front();
                        chk("done_kind", e.kind, K_DONE);
                        chk("pass_cnt", PASS_CNT, e.pcnt);
                        chk("fail_cnt", FAIL_CNT, e.fcnt);
                        if (e.fcnt > 0) chk("first_fail_idx", FIRST_FAIL_IDX, e.ffi);
                        chk("done_busy", BUSY, 0);
                    end
                end

                if (TIMEOUT_ERR && !te_p) begin
                    if (q.size() == 0) chk("unexpected_timeout", 32'd1, 32'd0);
                    else begin
                        e = q.pop_front();
                        chk("to_kind", e.kind, K_TO);
                        chk("to_latency", cyc - pulse_end, 32);
                        chk("to_busy", BUSY, 0);
                        chk("to_no_done", DONE, 0);
                    end
                end

                wr_p = WR; rd_p = RD; oe_p = DATA_OE; te_p = TIMEOUT_ERR;
            end
        end
    end

    task automatic start_seq(input logic [1:0] m);
        @(negedge CLK);
        MODE  = m;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((BUSY || q.size() != 0) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 3000) chk("idle_wait_expired", 32'd1, 32'd0);
        repeat (4) @(negedge CLK);
    endtask

    task automatic push_full(input int p, input int f, input int ffi);
        for (int i = 0; i < 4; i++) q.push_back(mk(K_WR, tbl_addr[i], tbl_data[i], 0, 0, 0));
        for (int i = 0; i < 4; i++) q.push_back(mk(K_RD, tbl_addr[i], 8'h00, 0, 0, 0));
        q.push_back(mk(K_DONE, 11'h0, 8'h00, p, f, ffi));
    endtask

    initial begin
        int n;
        tbl_addr[0] = 11'h010; tbl_addr[1] = 11'h011; tbl_addr[2] = 11'h7FF; tbl_addr[3] = 11'h000;
        tbl_data[0] = 8'hA5;   tbl_data[1] = 8'h5A;   tbl_data[2] = 8'hFF;   tbl_data[3] = 8'h00;
        ack_inject = 1'b0;

        repeat (3) @(negedge CLK);
        chk("rst_wr", WR, 0);
        chk("rst_rd", RD, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_oe", DATA_OE, 0);
        chk("rst_to", TIMEOUT_ERR, 0);
        chk("rst_cnts", {PASS_CNT, FAIL_CNT, TBL_IDX}, 0);
        RESET_N = 1'b1;

        // 1: write then verify, all matching
        push_full(4, 0, 0);
        start_seq(2'd0);
        wait_idle();

        // 2: controller returns 0x00 for address 0x011
        corrupt_en = 1'b1;
        push_full(3, 1, 1);
        start_seq(2'd0);
        wait_idle();
        corrupt_en = 1'b0;

        // 3: write only
        for (int i = 0; i < 4; i++) q.push_back(mk(K_WR, tbl_addr[i], tbl_data[i], 0, 0, 0));
        q.push_back(mk(K_DONE, 11'h0, 8'h00, 0, 0, 0));
        start_seq(2'd1);
        wait_idle();

        // 4: ACK never arrives
        ack_en = 1'b0;
        q.push_back(mk(K_WR, tbl_addr[0], tbl_data[0], 0, 0, 0));
        q.push_back(mk(K_TO, 11'h0, 8'h00, 0, 0, 0));
        start_seq(2'd1);
        wait_idle();
        chk("to_sticky", TIMEOUT_ERR, 1);
        ack_en = 1'b1;

        // 5: reset during the pulse of transaction 2
        for (int i = 0; i < 3; i++) q.push_back(mk(K_WR, tbl_addr[i], tbl_data[i], 0, 0, 0));
        start_seq(2'd0);
        chk("to_cleared_on_start", TIMEOUT_ERR, 0);
        n = 0;
        while (!(WR && TBL_IDX == 2'd2) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 500) chk("txn2_pulse_wait_expired", 32'd1, 32'd0);
        RESET_N = 1'b0;
        @(negedge CLK);
        chk("midrst_wr", WR, 0);
        chk("midrst_oe", DATA_OE, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_cnts", {PASS_CNT, FAIL_CNT, TBL_IDX}, 0);
        q.delete();
        @(negedge CLK);
        RESET_N = 1'b1;
        push_full(4, 0, 0);
        start_seq(2'd0);
        wait_idle();

        // 6: repeated START while busy and a stray ACK during GAP
        push_full(4, 0, 0);
        start_seq(2'd0);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        ack_inject = 1'b1;
        @(negedge CLK);
        ack_inject = 1'b0;
        chk("busy_after_stray", BUSY, 1);
        wait_idle();
        chk("final_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
